id_ex_stage: RTL

Decode-to-execute pipeline stage of the 5-stage RISC-V core. Captures the register-file read data (`rd1`/`rd2`) and the decoded instruction fields into the ID/EX pipeline register, and detects load-use hazards. On a hazard it stalls IF/ID and inserts a single bubble. It also honours back-pressure from EX, honours flushes from branch resolution, and keeps a saturating load-use stall counter.

---
 rtl/id_ex_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, EX back-pressure,
// flush and a saturating load-use counter. Optional WB_BYPASS_EN forwards WB data.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [31:0]       rf_rd1,
  input  logic [31:0]       rf_rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  lu_stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       imm;
    logic [31:0]       op1;
    logic [31:0]       op2;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic              mem_read;
    logic              reg_write;
  } ex_reg_t;

  ex_reg_t          ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  logic [31:0]      op1, op2;

  assign load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((id_uses_rs1 && id_rs1 == ex_q.rd) || (id_uses_rs2 && id_rs2 == ex_q.rd));

  // rst gates the stall so every output reads 0 while reset is held
  assign stall_if_id = rst && !flush && (!ex_ready || load_use);

  always_comb begin
    op1 = rf_rd1;
    op2 = rf_rd2;
`ifdef WB_BYPASS_EN
    if (wb_we && wb_rd != 5'd0 && wb_rd == id_rs1) op1 = wb_data;
    if (wb_we && wb_rd != 5'd0 && wb_rd == id_rs2) op2 = wb_data;
`endif
    // x0 read data from the register file is not trusted
    if (id_rs1 == 5'd0) op1 = '0;
    if (id_rs2 == 5'd0) op2 = '0;
  end

`ifndef WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
`endif

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d.valid = 1'b0;
    end else if (!ex_ready) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d.valid     = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.reg_write = 1'b0;
    end else begin
      ex_d.valid     = id_valid;
      ex_d.pc        = id_pc;
      ex_d.imm       = id_imm;
      ex_d.op1       = op1;
      ex_d.op2       = op2;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.rd        = id_rd;
      ex_d.ctrl      = id_ctrl;
      ex_d.mem_read  = id_valid && id_mem_read;
      ex_d.reg_write = id_valid && id_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (!flush && ex_ready && load_use && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_imm       = ex_q.imm;
  assign ex_op1       = ex_q.op1;
  assign ex_op2       = ex_q.op2;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_reg_write = ex_q.reg_write;
  assign lu_stall_cnt = cnt_q;

endmodule
